// File: rtl/laser_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : laser_sched_pkg
// Brief   : Shared types, state encodings and result codes for the LASER
//           two-requester job scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package laser_sched_pkg;

    localparam int NPTS = 40;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_LOAD   = 3'd1;
    localparam state_t c_ST_KICK   = 3'd2;
    localparam state_t c_ST_STREAM = 3'd3;
    localparam state_t c_ST_WAIT   = 3'd4;
    localparam state_t c_ST_RESP   = 3'd5;

    typedef logic [1:0] err_t;
    localparam err_t ERR_OK      = 2'd0;
    localparam err_t ERR_SHORT   = 2'd1;
    localparam err_t ERR_TIMEOUT = 2'd2;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } point_t;

endpackage
`default_nettype wire

// File: rtl/laser_pt_buf.sv
`default_nettype none
// ============================================================================
// Module  : laser_pt_buf
// Brief   : Job point buffer; synchronous write, combinational read, no reset.
// Rev     : 1.0  initial release
// ============================================================================
module laser_pt_buf
    import laser_sched_pkg::*;
#(
    parameter int DEPTH = NPTS,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam logic [AW-1:0] c_depth = AW'(DEPTH);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < c_depth)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the end read as zero (the read pointer parks at DEPTH).
    assign rd_data = (rd_addr < c_depth) ? r_mem[rd_addr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/laser_job_sched.sv
`default_nettype none
// ============================================================================
// Module  : laser_job_sched
// Brief   : Round-robin two-requester job scheduler in front of the LASER
//           two-circle coverage engine: buffer, replay, await DONE, report.
// Rev     : 1.0  initial release
// ============================================================================
module laser_job_sched
    import laser_sched_pkg::*;
#(
    parameter int NPTS    = 40,
    parameter int TIMEOUT = 1000000,
    parameter int TW      = 20
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [3:0] REQ0_X,
    input  logic [3:0] REQ0_Y,
    input  logic       REQ0_LAST,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [3:0] REQ1_X,
    input  logic [3:0] REQ1_Y,
    input  logic       REQ1_LAST,
    output logic       ENG_RST,
    output logic [3:0] ENG_X,
    output logic [3:0] ENG_Y,
    input  logic       ENG_DONE,
    input  logic [3:0] ENG_C1X,
    input  logic [3:0] ENG_C1Y,
    input  logic [3:0] ENG_C2X,
    input  logic [3:0] ENG_C2Y,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic       RES_ID,
    output logic [7:0] RES_C1,
    output logic [7:0] RES_C2,
    output logic [1:0] RES_ERR
);

    localparam logic [5:0]    c_last_idx = 6'(NPTS - 1);
    localparam logic [5:0]    c_npts     = 6'(NPTS);
    localparam logic [TW-1:0] c_tmo_max  = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic          r_grant;
    logic          r_rr_ptr;
    logic [5:0]    r_wr_ptr;
    logic [5:0]    r_rd_ptr;
    logic [TW-1:0] r_tmo;
    logic          r_eng_rst;
    point_t        r_eng_pt;
    logic          r_res_valid;
    logic          r_res_id;
    point_t        r_res_c1;
    point_t        r_res_c2;
    err_t          r_res_err;

    logic          w_in_load;
    logic          w_sel_valid;
    logic          w_sel_last;
    logic          w_accept;
    point_t        w_sel_pt;
    point_t        w_rd_data;

    assign w_in_load   = (r_state == c_ST_LOAD);
    assign REQ0_READY  = w_in_load && !r_grant;
    assign REQ1_READY  = w_in_load &&  r_grant;
    assign w_sel_valid = r_grant ? REQ1_VALID : REQ0_VALID;
    assign w_sel_last  = r_grant ? REQ1_LAST  : REQ0_LAST;
    assign w_sel_pt    = r_grant ? {REQ1_Y, REQ1_X} : {REQ0_Y, REQ0_X};
    assign w_accept    = w_in_load && w_sel_valid;

    laser_pt_buf #(
        .DEPTH (NPTS),
        .AW    (6)
    ) u_buf (
        .clk     (CLK),
        .wr_en   (w_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (w_sel_pt),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // r_rr_ptr holds the last-served requester; resetting it to 1 makes req0 win first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= 1'b0;
            r_rr_ptr    <= 1'b1;
            r_wr_ptr    <= 6'd0;
            r_rd_ptr    <= 6'd0;
            r_tmo       <= '0;
            r_eng_rst   <= 1'b1;
            r_eng_pt    <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_c1    <= '0;
            r_res_c2    <= '0;
            r_res_err   <= ERR_OK;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (REQ0_VALID || REQ1_VALID) begin
                        r_grant  <= (REQ0_VALID && REQ1_VALID) ? !r_rr_ptr : REQ1_VALID;
                        r_wr_ptr <= 6'd0;
                        r_state  <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + 6'd1;
                        if (r_wr_ptr == c_last_idx) begin
                            r_rd_ptr <= 6'd0;
                            r_state  <= c_ST_KICK;
                        end else if (w_sel_last) begin
                            r_res_valid <= 1'b1;
                            r_res_id    <= r_grant;
                            r_res_c1    <= '0;
                            r_res_c2    <= '0;
                            r_res_err   <= ERR_SHORT;
                            r_state     <= c_ST_RESP;
                        end
                    end
                end
                c_ST_KICK: begin
                    r_eng_pt  <= w_rd_data;
                    r_rd_ptr  <= r_rd_ptr + 6'd1;
                    r_eng_rst <= 1'b0;
                    r_state   <= c_ST_STREAM;
                end
                // r_rd_ptr runs one ahead of the point currently on ENG_X/ENG_Y.
                c_ST_STREAM: begin
                    if (r_rd_ptr == c_npts) begin
                        r_tmo   <= '0;
                        r_state <= c_ST_WAIT;
                    end else begin
                        r_eng_pt <= w_rd_data;
                        r_rd_ptr <= r_rd_ptr + 6'd1;
                    end
                end
                c_ST_WAIT: begin
                    if (ENG_DONE) begin
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_grant;
                        r_res_c1    <= {ENG_C1Y, ENG_C1X};
                        r_res_c2    <= {ENG_C2Y, ENG_C2X};
                        r_res_err   <= ERR_OK;
                        r_eng_rst   <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else if (r_tmo == c_tmo_max) begin
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_grant;
                        r_res_c1    <= '0;
                        r_res_c2    <= '0;
                        r_res_err   <= ERR_TIMEOUT;
                        r_eng_rst   <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                c_ST_RESP: begin
                    if (RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_rr_ptr    <= r_res_id;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_eng_rst <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ENG_RST   = r_eng_rst;
    assign ENG_X     = r_eng_pt.x;
    assign ENG_Y     = r_eng_pt.y;
    assign RES_VALID = r_res_valid;
    assign RES_ID    = r_res_id;
    assign RES_C1    = r_res_c1;
    assign RES_C2    = r_res_c2;
    assign RES_ERR   = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_laser_job_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_laser_job_sched
// Brief   : Directed self-checking bench for laser_job_sched.
// Rev     : 1.0  initial release
// ============================================================================
module tb_laser_job_sched;

    localparam int c_npts    = 40;
    localparam int c_timeout = 200;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0_VALID = 1'b0, REQ0_LAST = 1'b0, REQ0_READY;
    logic [3:0] REQ0_X = 4'h0, REQ0_Y = 4'h0;
    logic       REQ1_VALID = 1'b0, REQ1_LAST = 1'b0, REQ1_READY;
    logic [3:0] REQ1_X = 4'h0, REQ1_Y = 4'h0;
    logic       ENG_RST;
    logic [3:0] ENG_X, ENG_Y;
    logic       ENG_DONE = 1'b0;
    logic [3:0] ENG_C1X = 4'h3, ENG_C1Y = 4'h4, ENG_C2X = 4'hA, ENG_C2Y = 4'hC;
    logic       RES_VALID, RES_ID;
    logic       RES_READY = 1'b0;
    logic [7:0] RES_C1, RES_C2;
    logic [1:0] RES_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int mon_falls = 0;
    int mon_run  = 0;
    int fall_cyc = 0;
    logic mon_prev = 1'b1;
    logic [7:0] mon_pts [64];
    logic [7:0] exp_pts [c_npts];
    int fb = 0;
    int ready_cyc = 0;
    int rw = 0;
    bit exp_ids [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    laser_job_sched #(
        .NPTS    (c_npts),
        .TIMEOUT (c_timeout),
        .TW      (20)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_X     (REQ0_X),
        .REQ0_Y     (REQ0_Y),
        .REQ0_LAST  (REQ0_LAST),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_X     (REQ1_X),
        .REQ1_Y     (REQ1_Y),
        .REQ1_LAST  (REQ1_LAST),
        .ENG_RST    (ENG_RST),
        .ENG_X      (ENG_X),
        .ENG_Y      (ENG_Y),
        .ENG_DONE   (ENG_DONE),
        .ENG_C1X    (ENG_C1X),
        .ENG_C1Y    (ENG_C1Y),
        .ENG_C2X    (ENG_C2X),
        .ENG_C2Y    (ENG_C2Y),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_ID     (RES_ID),
        .RES_C1     (RES_C1),
        .RES_C2     (RES_C2),
        .RES_ERR    (RES_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt++;

    // Engine-side observer: each low run of ENG_RST is recorded from index 0.
    always @(negedge CLK) begin
        if (ENG_RST === 1'b0) begin
            if (mon_prev) begin
                mon_falls++;
                mon_run  = 0;
                fall_cyc = cyc_cnt;
            end
            if (mon_run < 64) mon_pts[mon_run] = {ENG_Y, ENG_X};
            mon_run++;
        end
        mon_prev = ENG_RST;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input logic v, input logic [7:0] p, input logic l);
        if (id) begin
            REQ1_VALID = v; REQ1_X = p[3:0]; REQ1_Y = p[7:4]; REQ1_LAST = l;
        end else begin
            REQ0_VALID = v; REQ0_X = p[3:0]; REQ0_Y = p[7:4]; REQ0_LAST = l;
        end
    endtask

    task automatic send_job(input bit id, input int n, input int last_idx, input int gap_at,
                            input int gap_len, input logic [7:0] base, output int rdy_wait);
        int i = 0;
        int g = 0;
        int w = 0;
        logic rdy;
        logic v;
        logic [7:0] p;
        rdy_wait = -1;
        while (i < n && w < 2000) begin
            @(negedge CLK);
            p = base + 8'(i * 13);
            if (i < c_npts) exp_pts[i] = p;
            if (i == gap_at && g < gap_len) begin
                drive(id, 1'b0, 8'h00, 1'b0);
                g++;
            end else begin
                drive(id, 1'b1, p, (i == last_idx));
            end
            rdy = id ? REQ1_READY : REQ0_READY;
            v   = id ? REQ1_VALID : REQ0_VALID;
            if (rdy && rdy_wait < 0) begin
                rdy_wait  = w;
                ready_cyc = cyc_cnt;
            end
            @(posedge CLK);
            if (rdy && v) i++;
            w++;
        end
        chk("beats_sent", i, n);
        @(negedge CLK);
        drive(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_wait_entry();
        int k = 0;
        while (!((mon_falls - fb) >= 1 && mon_run >= c_npts) && k < 3000) begin
            @(posedge CLK);
            k++;
        end
        chk("stream_seen", ((mon_falls - fb) >= 1 && mon_run >= c_npts), 1);
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) @(posedge CLK);
        @(negedge CLK);
        ENG_DONE = 1'b1;
        chk("res_valid_before_done", RES_VALID, 1'b0);
        @(negedge CLK);
        ENG_DONE = 1'b0;
        chk("res_valid_after_done", RES_VALID, 1'b1);
    endtask

    task automatic wait_res();
        int k = 0;
        while (RES_VALID !== 1'b1 && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        chk("res_valid_wait", RES_VALID, 1'b1);
    endtask

    task automatic handshake();
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        chk("res_valid_drop", RES_VALID, 1'b0);
    endtask

    task automatic chk_stream(input string tag);
        int bad = 0;
        for (int i = 0; i < c_npts; i++) begin
            if (mon_pts[i] !== exp_pts[i]) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic chk_res(input string tag, input logic id, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [1:0] err);
        chk({tag, "_id"},  RES_ID,  id);
        chk({tag, "_c1"},  RES_C1,  c1);
        chk({tag, "_c2"},  RES_C2,  c2);
        chk({tag, "_err"}, RES_ERR, err);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_req0_ready", REQ0_READY, 1'b0);
        chk("rst_req1_ready", REQ1_READY, 1'b0);
        chk("rst_eng_rst", ENG_RST, 1'b1);
        chk("rst_eng_x", ENG_X, 4'h0);
        chk("rst_eng_y", ENG_Y, 4'h0);
        chk("rst_res_valid", RES_VALID, 1'b0);
        chk_res("rst", 1'b0, 8'h00, 8'h00, 2'd0);
        RST_N = 1'b1;

        // Single job from req0
        fb = mon_falls;
        send_job(1'b0, 40, 39, -1, 0, 8'h10, rw);
        chk("ready_latency", rw, 1);
        wait_wait_entry();
        chk("stream_start_latency", fall_cyc - ready_cyc, 41);
        pulse_done(100);
        chk_res("single", 1'b0, 8'h43, 8'hCA, 2'd0);
        chk_stream("single_stream");
        chk("single_rst_low_cycles", mon_run, 141);
        chk("single_rst_falls", mon_falls - fb, 1);
        handshake();

        // Arbitration straight after reset: both valid, then req1 alone
        @(negedge CLK); RST_N = 1'b0;
        repeat (2) @(negedge CLK); RST_N = 1'b1;
        drive(1'b0, 1'b1, 8'h21, 1'b0);
        drive(1'b1, 1'b1, 8'h12, 1'b0);
        for (int j = 0; j < 5; j++) begin
            fb = mon_falls;
            wait_wait_entry();
            pulse_done(3);
            chk("arb_id", RES_ID, exp_ids[j]);
            chk("arb_err", RES_ERR, 2'd0);
            if (j == 2) drive(1'b0, 1'b0, 8'h00, 1'b0);
            if (j == 4) drive(1'b1, 1'b0, 8'h00, 1'b0);
            handshake();
        end

        // Short frame, then a normal job
        fb = mon_falls;
        send_job(1'b0, 11, 10, -1, 0, 8'h30, rw);
        wait_res();
        chk_res("short", 1'b0, 8'h00, 8'h00, 2'd1);
        chk("short_eng_rst", ENG_RST, 1'b1);
        handshake();
        repeat (5) @(negedge CLK);
        chk("short_no_stream", mon_falls - fb, 0);
        fb = mon_falls;
        send_job(1'b0, 40, 39, -1, 0, 8'h55, rw);
        wait_wait_entry();
        pulse_done(10);
        chk_res("after_short", 1'b0, 8'h43, 8'hCA, 2'd0);
        chk_stream("after_short_stream");
        handshake();

        // Timeout: no DONE from the engine
        fb = mon_falls;
        send_job(1'b1, 40, 39, -1, 0, 8'h77, rw);
        wait_wait_entry();
        @(negedge CLK);
        repeat (199) @(negedge CLK);
        chk("tmo_not_yet", RES_VALID, 1'b0);
        @(negedge CLK);
        chk("tmo_res_valid", RES_VALID, 1'b1);
        chk_res("tmo", 1'b1, 8'h00, 8'h00, 2'd2);
        chk("tmo_eng_rst", ENG_RST, 1'b1);
        chk("tmo_rst_low_cycles", mon_run, 240);
        handshake();

        // DONE on the expiry cycle wins
        fb = mon_falls;
        send_job(1'b0, 40, 39, -1, 0, 8'h99, rw);
        wait_wait_entry();
        pulse_done(199);
        chk_res("expiry_done", 1'b0, 8'h43, 8'hCA, 2'd0);
        handshake();

        // VALID gap mid-LOAD, then result backpressure
        fb = mon_falls;
        send_job(1'b0, 40, 39, 15, 5, 8'hA7, rw);
        wait_wait_entry();
        pulse_done(5);
        chk_stream("gap_stream");
        chk("gap_rst_falls", mon_falls - fb, 1);
        chk("gap_rst_low_cycles", mon_run, 46);
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            chk("bp_res_valid", RES_VALID, 1'b1);
            chk("bp_res_c1", RES_C1, 8'h43);
            chk("bp_res_c2", RES_C2, 8'hCA);
            chk("bp_res_id", RES_ID, 1'b0);
            chk("bp_req1_ready", REQ1_READY, 1'b0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        handshake();

        // Asynchronous reset during STREAM cycle 20
        fb = mon_falls;
        send_job(1'b0, 40, 39, -1, 0, 8'h3C, rw);
        begin
            int k = 0;
            while (!((mon_falls - fb) >= 1 && mon_run >= 20) && k < 3000) begin
                @(posedge CLK);
                k++;
            end
        end
        chk("arst_stream_reached", mon_run, 20);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_eng_rst", ENG_RST, 1'b1);
        chk("arst_eng_x", ENG_X, 4'h0);
        chk("arst_eng_y", ENG_Y, 4'h0);
        chk("arst_res_valid", RES_VALID, 1'b0);
        chk("arst_req0_ready", REQ0_READY, 1'b0);
        chk_res("arst", 1'b0, 8'h00, 8'h00, 2'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        fb = mon_falls;
        send_job(1'b0, 40, 39, -1, 0, 8'hE1, rw);
        chk("post_arst_ready_latency", rw, 1);
        wait_wait_entry();
        chk("post_arst_stream_latency", fall_cyc - ready_cyc, 41);
        pulse_done(7);
        chk_res("post_arst", 1'b0, 8'h43, 8'hCA, 2'd0);
        chk_stream("post_arst_stream");
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
